keypad_scanner_n: RTL

- Parametrised successor to the 4x4 keypad scanner for an NxM active-high row/column matrix.
- Drives one-hot rows and samples columns at a divided tick rate.
- Debounces both press and release of a single key and optionally generates typematic repeats.
- Queues key events in a small FIFO that downstream logic (display mux, code register) drains with a valid/ready handshake.

---
 rtl/keypad_scanner_n_if.sv | 12 +
 rtl/keypad_scanner_n.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner_n_if.sv
// Event stream between the keypad scanner and its consumer.
// The master presents queued key codes and the slave accepts them with a valid/ready handshake.
interface keypad_scanner_n_if #(
    parameter int CODE_W = 6
);
    logic              ev_valid;
    logic              ev_ready;
    logic [CODE_W-1:0] ev_code;

    modport master (output ev_valid, output ev_code, input ev_ready);
    modport slave  (input ev_valid, input ev_code, output ev_ready);
endinterface

// File: rtl/keypad_scanner_n.sv
// NxM keypad scanner: one-hot row drive, press/release debounce, typematic repeat,
// and a small event FIFO drained over a valid/ready interface.
//
// state    | meaning
// SCAN     | stepping rows, looking for exactly one active column
// DEBOUNCE | candidate key latched, counting stable ticks before accepting the press
// HOLD     | key accepted, generating repeats while it stays down
// RELEASE  | key seen up, counting stable ticks before accepting the release
module keypad_scanner_n #(
    parameter int NUM_ROWS       = 4,
    parameter int NUM_COLS       = 4,
    parameter int TICK_DIV       = 48000,
    parameter int DEBOUNCE_TICKS = 50,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_COLS-1:0] col_i,
    input  logic                repeat_en_i,
    input  logic                release_en_i,
    input  logic                clear_ovf_i,
    output logic [NUM_ROWS-1:0] row_o,
    output logic                overflow_o,
    output logic                busy_o,
    keypad_scanner_n_if.master  ev_if
);
    localparam int RW     = $clog2(NUM_ROWS);
    localparam int CW     = $clog2(NUM_COLS);
    localparam int CODE_W = 2 + RW + CW;
    localparam int TW     = $clog2(TICK_DIV);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int MAX_A  = (DEBOUNCE_TICKS > REPEAT_DELAY) ? DEBOUNCE_TICKS : REPEAT_DELAY;
    localparam int MAX_C  = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;
    localparam int CNT_W  = $clog2(MAX_C + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     tick_cnt_q;
    logic [RW-1:0]     row_idx_q, row_idx_d, row_next;
    logic [RW-1:0]     lat_row_q, lat_row_d;
    logic [CW-1:0]     lat_col_q, lat_col_d, hot_idx;
    logic [CNT_W-1:0]  cnt_q, cnt_d, rcnt_q, rcnt_d, rcnt_inc, rep_limit;
    logic              rep_on_q, rep_on_d;
    logic              tick, one_hot, key_on;
    logic              push;
    logic [1:0]        push_type;
    logic [CODE_W-1:0] push_code;

    logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q, rd_ptr_q;
    logic              full, empty, pop, wr_en, drop;

    assign tick     = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign one_hot  = $onehot(col_i);
    assign key_on   = col_i[lat_col_q];
    assign row_next = (row_idx_q == RW'(NUM_ROWS - 1)) ? '0 : row_idx_q + RW'(1);
    assign rcnt_inc = rcnt_q + CNT_W'(1);
    assign rep_limit = rep_on_q ? CNT_W'(REPEAT_RATE) : CNT_W'(REPEAT_DELAY);
    assign push_code = {push_type, lat_row_q, lat_col_q};

    always_comb begin
        hot_idx = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (col_i[i]) hot_idx = CW'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        lat_row_d = lat_row_q;
        lat_col_d = lat_col_q;
        cnt_d     = cnt_q;
        rcnt_d    = rcnt_q;
        rep_on_d  = rep_on_q;
        push      = 1'b0;
        push_type = 2'b00;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (one_hot) begin
                        lat_row_d = row_idx_q;
                        lat_col_d = hot_idx;
                        cnt_d     = CNT_W'(1);
                        state_d   = DEBOUNCE;
                    end else begin
                        row_idx_d = row_next;
                    end
                end
                DEBOUNCE: begin
                    if (one_hot && key_on) begin
                        if (cnt_q == CNT_W'(DEBOUNCE_TICKS)) begin
                            push     = 1'b1;
                            cnt_d    = '0;
                            rcnt_d   = '0;
                            rep_on_d = 1'b0;
                            state_d  = HOLD;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d     = '0;
                        row_idx_d = row_next;
                        state_d   = SCAN;
                    end
                end
                HOLD: begin
                    if (key_on) begin
                        if (!repeat_en_i) begin
                            rcnt_d = '0;
                        end else if (rcnt_inc == rep_limit) begin
                            push      = 1'b1;
                            push_type = 2'b01;
                            rcnt_d    = '0;
                            rep_on_d  = 1'b1;
                        end else begin
                            rcnt_d = rcnt_inc;
                        end
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    // A bounce back to HOLD keeps rcnt so repeat cadence is not disturbed.
                    if (key_on) begin
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else if (cnt_q == CNT_W'(DEBOUNCE_TICKS)) begin
                        push      = release_en_i;
                        push_type = 2'b10;
                        cnt_d     = '0;
                        row_idx_d = row_next;
                        state_d   = SCAN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tick_cnt_q <= '0;
            state_q    <= SCAN;
            row_idx_q  <= '0;
            lat_row_q  <= '0;
            lat_col_q  <= '0;
            cnt_q      <= '0;
            rcnt_q     <= '0;
            rep_on_q   <= 1'b0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
            state_q    <= state_d;
            row_idx_q  <= row_idx_d;
            lat_row_q  <= lat_row_d;
            lat_col_q  <= lat_col_d;
            cnt_q      <= cnt_d;
            rcnt_q     <= rcnt_d;
            rep_on_q   <= rep_on_d;
        end
    end

    always_comb begin
        busy_o = (state_q != SCAN);
        row_o  = NUM_ROWS'(1) << (busy_o ? lat_row_q : row_idx_q);
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && ev_if.ev_ready;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    assign ev_if.ev_valid = !empty;
    assign ev_if.ev_code  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_o <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            if (wr_en) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_code;
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
            end
            if (drop)             overflow_o <= 1'b1;
            else if (clear_ovf_i) overflow_o <= 1'b0;
        end
    end
endmodule
